// File: rtl/acc_operand_sel_if.sv
// Handshake bundle between the operand selector, its upstream source
// and the accumulator that consumes the selected operand.
interface acc_operand_sel_if #(
  parameter int N_BUS = 16,
  parameter int N_SRC = 3,
  parameter int TAM   = 2
);
  logic [TAM-1:0]         i_sel;
  logic [N_SRC*N_BUS-1:0] i_src;
  logic                   i_valid;
  logic                   o_ready;
  logic [N_BUS-1:0]       o_data;
  logic [TAM-1:0]         o_tag;
  logic                   o_valid;
  logic                   i_ready;
  logic                   i_err_clr;
  logic                   o_sel_err;

  modport slave (
    input  i_sel, i_src, i_valid,
    input  i_ready, i_err_clr,
    output o_ready, o_data, o_tag,
    output o_valid, o_sel_err
  );

  modport master (
    output i_sel, i_src, i_valid,
    output i_ready, i_err_clr,
    input  o_ready, o_data, o_tag,
    input  o_valid, o_sel_err
  );
endinterface

// File: rtl/acc_operand_sel.sv
// Registered operand selector for the BIP accumulator with a 2-entry
// skid buffer and a sticky illegal-select flag.
module acc_operand_sel #(
  parameter int N_BUS    = 16,
  parameter int N_SRC    = 3,
  parameter int TAM      = 2,
  parameter int N_IMM    = 11,
  parameter int SEXT_SRC = 1
) (
  input logic              i_clk,
  input logic              i_reset,
  acc_operand_sel_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state, state_n;

  logic [N_BUS-1:0] main_data;
  logic [TAM-1:0]   main_tag;
  logic [N_BUS-1:0] skid_data;
  logic [TAM-1:0]   skid_tag;
  logic             sel_err;

  logic [N_BUS-1:0] raw;
  logic [N_BUS-1:0] sel_data;
  logic             sel_ok;
  logic             acc;
  logic             con;
  logic             ld_main;
  logic             ld_skid;
  logic             ld_fwd;

  assign sel_ok = {1'b0, bus.i_sel} < (TAM+1)'(N_SRC);

  always_comb begin
    raw = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (bus.i_sel == TAM'(k))
        raw = bus.i_src[k*N_BUS +: N_BUS];
    end
  end

  // Illegal selects yield zero rather than whatever was last latched.
  always_comb begin
    sel_data = raw;
    if (bus.i_sel == TAM'(SEXT_SRC)) begin
      for (int i = 0; i < N_BUS; i++)
        sel_data[i] = (i < N_IMM) ? raw[i] : raw[N_IMM-1];
    end
    if (!sel_ok)
      sel_data = '0;
  end

  assign bus.o_valid   = (state != EMPTY);
  assign bus.o_ready   = (state != TWO);
  assign bus.o_data    = main_data;
  assign bus.o_tag     = main_tag;
  assign bus.o_sel_err = sel_err;

  assign acc = bus.i_valid && bus.o_ready;
  assign con = bus.o_valid && bus.i_ready;

  always_comb begin
    state_n = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    ld_fwd  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          ld_main = 1'b1;
          state_n = ONE;
        end
      end
      ONE: begin
        if (acc && con) begin
          ld_main = 1'b1;
        end else if (acc) begin
          ld_skid = 1'b1;
          state_n = TWO;
        end else if (con) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (con) begin
          ld_fwd  = 1'b1;
          state_n = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_tag  <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      state <= state_n;
      if (ld_main) begin
        main_data <= sel_data;
        main_tag  <= bus.i_sel;
      end else if (ld_fwd) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
      end
      if (ld_skid) begin
        skid_data <= sel_data;
        skid_tag  <= bus.i_sel;
      end
    end
  end

  // A new illegal accept outranks a clear on the same edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      sel_err <= 1'b0;
    else if (acc && !sel_ok)
      sel_err <= 1'b1;
    else if (bus.i_err_clr)
      sel_err <= 1'b0;
  end

endmodule

// File: tb/tb_acc_operand_sel.sv
// Directed bench for acc_operand_sel: driver pushes expected operands,
// a monitor pops them as the accumulator consumes.
module tb_acc_operand_sel;

  logic clk = 1'b0;
  logic rst = 1'b1;

  acc_operand_sel_if #(
    .N_BUS(16),
    .N_SRC(3),
    .TAM(2)
  ) bus ();

  acc_operand_sel #(
    .N_BUS(16),
    .N_SRC(3),
    .TAM(2),
    .N_IMM(11),
    .SEXT_SRC(1)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] sel,
                       input logic [15:0] val, input bit rdy,
                       input bit clr, input logic [15:0] exp);
    logic [47:0] s;
    s = {16'hDEAD, 16'hDEAD, 16'hDEAD};
    if (sel < 2'd3)
      s[sel*16 +: 16] = val;
    bus.i_valid   = v;
    bus.i_sel     = sel;
    bus.i_src     = s;
    bus.i_ready   = rdy;
    bus.i_err_clr = clr;
    if (v && bus.o_ready)
      exp_q.push_back({exp, sel});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      logic [17:0] e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got %0h with no expected entry",
                 bus.o_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {16'h0, bus.o_data}, {16'h0, e[17:2]});
        chk("sb_tag", {30'h0, bus.o_tag}, {30'h0, e[1:0]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid   = 1'b0;
    bus.i_sel     = '0;
    bus.i_src     = '0;
    bus.i_ready   = 1'b0;
    bus.i_err_clr = 1'b0;
    #3;
    chk("rst_valid", {31'h0, bus.o_valid}, 0);
    chk("rst_ready", {31'h0, bus.o_ready}, 1);
    chk("rst_data", {16'h0, bus.o_data}, 0);
    chk("rst_tag", {30'h0, bus.o_tag}, 0);
    chk("rst_err", {31'h0, bus.o_sel_err}, 0);
    #9 rst = 1'b0;

    // streaming, one operand per cycle
    drive(1, 2'd0, 16'h1234, 1, 0, 16'h1234);
    tick();
    chk("lat_valid", {31'h0, bus.o_valid}, 1);
    chk("lat_data", {16'h0, bus.o_data}, 32'h1234);
    chk("lat_tag", {30'h0, bus.o_tag}, 0);
    drive(1, 2'd1, 16'hAC00, 1, 0, 16'hFC00);
    tick();
    chk("sext_neg", {16'h0, bus.o_data}, 32'hFC00);
    drive(1, 2'd1, 16'h5BFF, 1, 0, 16'h03FF);
    tick();
    chk("sext_pos", {16'h0, bus.o_data}, 32'h03FF);
    drive(1, 2'd2, 16'hBEEF, 1, 0, 16'hBEEF);
    tick();
    chk("no_bubble", {31'h0, bus.o_valid}, 1);
    chk("src2_data", {16'h0, bus.o_data}, 32'hBEEF);
    drive(0, 2'd0, 16'h0, 1, 0, 16'h0);
    tick();
    chk("drain_valid", {31'h0, bus.o_valid}, 0);

    // stall: A in main, B in skid, C refused
    drive(1, 2'd0, 16'h000A, 0, 0, 16'h000A);
    tick();
    drive(1, 2'd2, 16'h000B, 0, 0, 16'h000B);
    tick();
    chk("two_ready", {31'h0, bus.o_ready}, 0);
    chk("two_data", {16'h0, bus.o_data}, 32'h000A);
    drive(1, 2'd0, 16'h000C, 0, 0, 16'h000C);
    tick();
    chk("hold_data", {16'h0, bus.o_data}, 32'h000A);
    chk("hold_ready", {31'h0, bus.o_ready}, 0);
    drive(1, 2'd0, 16'h000C, 1, 0, 16'h000C);
    tick();
    chk("fwd_data", {16'h0, bus.o_data}, 32'h000B);
    drive(1, 2'd0, 16'h000C, 1, 0, 16'h000C);
    tick();
    chk("c_data", {16'h0, bus.o_data}, 32'h000C);
    drive(0, 2'd0, 16'h0, 1, 0, 16'h0);
    tick();

    // illegal select and sticky flag
    drive(1, 2'd3, 16'h7777, 1, 0, 16'h0000);
    tick();
    chk("ill_data", {16'h0, bus.o_data}, 0);
    chk("ill_tag", {30'h0, bus.o_tag}, 3);
    chk("ill_err", {31'h0, bus.o_sel_err}, 1);
    drive(0, 2'd0, 16'h0, 1, 0, 16'h0);
    tick();
    chk("err_sticky", {31'h0, bus.o_sel_err}, 1);
    drive(1, 2'd3, 16'h7777, 1, 1, 16'h0000);
    tick();
    chk("err_set_wins", {31'h0, bus.o_sel_err}, 1);
    drive(0, 2'd0, 16'h0, 1, 1, 16'h0);
    tick();
    chk("err_clr", {31'h0, bus.o_sel_err}, 0);

    // refused illegal select leaves flag clear
    drive(1, 2'd0, 16'h0111, 0, 0, 16'h0111);
    tick();
    drive(1, 2'd0, 16'h0222, 0, 0, 16'h0222);
    tick();
    drive(1, 2'd3, 16'h0, 0, 0, 16'h0);
    tick();
    chk("refused_err", {31'h0, bus.o_sel_err}, 0);
    chk("refused_ready", {31'h0, bus.o_ready}, 0);

    // asynchronous reset while full
    bus.i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, bus.o_valid}, 0);
    chk("arst_ready", {31'h0, bus.o_ready}, 1);
    chk("arst_data", {16'h0, bus.o_data}, 0);
    exp_q.delete();
    #2 rst = 1'b0;
    tick();
    drive(1, 2'd2, 16'h0ABC, 0, 0, 16'h0ABC);
    tick();
    chk("x_valid", {31'h0, bus.o_valid}, 1);
    chk("x_data", {16'h0, bus.o_data}, 32'h0ABC);
    drive(0, 2'd0, 16'h0, 0, 0, 16'h0);
    tick();
    chk("x_alone", {16'h0, bus.o_data}, 32'h0ABC);
    chk("x_ready", {31'h0, bus.o_ready}, 1);
    drive(0, 2'd0, 16'h0, 1, 0, 16'h0);
    tick();
    chk("x_drained", {31'h0, bus.o_valid}, 0);
    tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
